// File: rtl/dekatron_step_sequencer.sv
// Drives the two guide pulses of a dekatron counting tube for one step at a time
// and keeps a one-hot shadow of the glowing cathode, with wrap carries.
module dekatron_step_sequencer #(
  parameter int PULSE_LEN  = 2,
  parameter int SETTLE_LEN = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic       i_dir,
  input  logic       i_set,
  input  logic [9:0] i_in,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pulse_right_n,
  output logic       o_pulse_left_n,
  output logic [9:0] o_pos,
  output logic       o_carry_high,
  output logic       o_carry_low
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_G1     = 2'd1,
    ST_G2     = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam logic [3:0] PULSE_LAST  = 4'(PULSE_LEN - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_LEN - 1);
  localparam bit         SKIP_SETTLE = (SETTLE_LEN == 0);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_dir;
  logic [9:0] r_pos;
  logic       r_busy;
  logic       r_done;
  logic       r_pulse_right_n;
  logic       r_pulse_left_n;
  logic       r_carry_high;
  logic       r_carry_low;

  state_t     w_state_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_dir_nxt;
  logic [9:0] w_pos_nxt;
  logic       w_done;
  logic       w_carry_high;
  logic       w_carry_low;
  logic       w_guide_a;
  logic       w_guide_b;

  // Lowest set bit of the load value; an empty load parks on cathode 0.
  function automatic logic [9:0] lowest_onehot(input logic [9:0] v);
    logic [9:0] r;
    r = 10'b0000000001;
    for (int k = 9; k >= 0; k--) begin
      if (v[k]) begin
        r    = 10'd0;
        r[k] = 1'b1;
      end
    end
    return r;
  endfunction

  // Next-state, counter, position and pulse-event decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_dir_nxt    = r_dir;
    w_pos_nxt    = r_pos;
    w_done       = 1'b0;
    w_carry_high = 1'b0;
    w_carry_low  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_set) begin
          w_pos_nxt = lowest_onehot(i_in);
        end else if (i_req) begin
          w_state_nxt = ST_G1;
          w_cnt_nxt   = 4'd0;
          w_dir_nxt   = i_dir;
        end else begin
          w_cnt_nxt = 4'd0;
        end
      end
      ST_G1: begin
        if (r_cnt == PULSE_LAST) begin
          w_state_nxt = ST_G2;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_G2: begin
        if (r_cnt == PULSE_LAST) begin
          w_cnt_nxt = 4'd0;
          // The glow has crossed to the neighbouring cathode; move the shadow with it.
          if (!r_dir) begin
            w_pos_nxt    = {r_pos[8:0], r_pos[9]};
            w_carry_high = r_pos[9];
          end else begin
            w_pos_nxt   = {r_pos[0], r_pos[9:1]};
            w_carry_low = r_pos[0];
          end
          if (SKIP_SETTLE) begin
            w_state_nxt = ST_IDLE;
            w_done      = 1'b1;
          end else begin
            w_state_nxt = ST_SETTLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
          w_done      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Guide A leads in the step direction; guide B follows. They are mutually exclusive by state.
  always_comb begin
    w_guide_a = (w_state_nxt == ST_G1);
    w_guide_b = (w_state_nxt == ST_G2);
  end

  // State, counter and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_cnt           <= 4'd0;
      r_dir           <= 1'b0;
      r_pos           <= 10'b0000000001;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pulse_right_n <= 1'b1;
      r_pulse_left_n  <= 1'b1;
      r_carry_high    <= 1'b0;
      r_carry_low     <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_dir           <= w_dir_nxt;
      r_pos           <= w_pos_nxt;
      r_busy          <= (w_state_nxt != ST_IDLE);
      r_done          <= w_done;
      r_pulse_right_n <= !((w_guide_a && !w_dir_nxt) || (w_guide_b && w_dir_nxt));
      r_pulse_left_n  <= !((w_guide_a && w_dir_nxt) || (w_guide_b && !w_dir_nxt));
      r_carry_high    <= w_carry_high;
      r_carry_low     <= w_carry_low;
    end
  end

  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_pulse_right_n = r_pulse_right_n;
  assign o_pulse_left_n  = r_pulse_left_n;
  assign o_pos           = r_pos;
  assign o_carry_high    = r_carry_high;
  assign o_carry_low     = r_carry_low;

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Randomized and directed bench for dekatron_step_sequencer against a timeline
// model: cycles since acceptance decide pulses, busy, done and the cathode index.
module tb_dekatron_step_sequencer;
  localparam int P = 2;
  localparam int S = 1;
  localparam int L = 2 * P + S + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       dir = 1'b0;
  logic       set = 1'b0;
  logic [9:0] in_v = 10'd0;

  logic       o_busy, o_done, o_pr_n, o_pl_n, o_ch, o_cl;
  logic [9:0] o_pos;
  logic [15:0] obs;

  int passed = 0;
  int total  = 0;

  // model: m_t = cycles since acceptance (0 = idle), m_idx = glowing cathode
  int m_t   = 0;
  int m_idx = 0;
  bit m_dir = 1'b0;
  bit m_ch  = 1'b0;
  bit m_cl  = 1'b0;

  always #5 clk = ~clk;

  dekatron_step_sequencer #(.PULSE_LEN(P), .SETTLE_LEN(S)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_dir(dir), .i_set(set), .i_in(in_v),
    .o_busy(o_busy), .o_done(o_done), .o_pulse_right_n(o_pr_n), .o_pulse_left_n(o_pl_n),
    .o_pos(o_pos), .o_carry_high(o_ch), .o_carry_low(o_cl)
  );

  assign obs = {o_busy, o_done, o_pr_n, o_pl_n, o_pos, o_ch, o_cl};

  function automatic int low_idx(input logic [9:0] v);
    for (int i = 0; i < 10; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [15:0] exp_vec();
    logic       busy, done, a_low, b_low, pr_n, pl_n;
    logic [9:0] p;
    busy  = (m_t >= 1) && (m_t <= 2 * P + S);
    done  = (m_t == L);
    a_low = (m_t >= 1) && (m_t <= P);
    b_low = (m_t > P) && (m_t <= 2 * P);
    pr_n  = !((a_low && !m_dir) || (b_low && m_dir));
    pl_n  = !((a_low && m_dir) || (b_low && !m_dir));
    p     = 10'd1;
    p     = p << m_idx;
    return {busy, done, pr_n, pl_n, p, m_ch, m_cl};
  endfunction

  // Advance one clock and update the model with the inputs sampled at that edge.
  task automatic tick();
    int old;
    bit idle;
    @(posedge clk);
    old  = m_t;
    idle = (old == 0) || (old == L);
    m_ch = 1'b0;
    m_cl = 1'b0;
    if (rst) begin
      m_t   = 0;
      m_idx = 0;
    end else begin
      if (idle) begin
        if (set) begin
          m_idx = low_idx(in_v);
          m_t   = 0;
        end else if (req) begin
          m_t   = 1;
          m_dir = dir;
        end else begin
          m_t = 0;
        end
      end else begin
        m_t = old + 1;
      end
      if (m_t == 2 * P + 1) begin
        if (!m_dir) begin
          m_ch  = (m_idx == 9);
          m_idx = (m_idx + 1) % 10;
        end else begin
          m_cl  = (m_idx == 0);
          m_idx = (m_idx + 9) % 10;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; set = 1'b1; dir = 1'b1; in_v = 10'h3FF;
    tick();
    tick();
    if (obs !== 16'b0011_0000_0000_0100) $display("FAIL reset_state got=%h exp=%h", obs, 16'b0011_0000_0000_0100);
    else passed++;
    total++;
    rst = 1'b0; req = 1'b0; set = 1'b0; dir = 1'b0; in_v = 10'd0;
    tick();
    if (obs !== exp_vec()) $display("FAIL reset_idle got=%h exp=%h", obs, exp_vec());
    else passed++;
    total++;
  endtask

  task automatic test_forward_step();
    logic [15:0] pr_mask = 16'd0, pl_mask = 16'd0, done_mask = 16'd0;
    req = 1'b1; dir = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      req = 1'b0;
      if (obs !== exp_vec()) $display("FAIL fwd_cycle c=%0d got=%h exp=%h", c, obs, exp_vec());
      else passed++;
      total++;
      if (!o_pr_n) pr_mask[c] = 1'b1;
      if (!o_pl_n) pl_mask[c] = 1'b1;
      if (o_done)  done_mask[c] = 1'b1;
    end
    if ({pr_mask, pl_mask, done_mask, o_pos} !== {16'h0006, 16'h0018, 16'h0040, 10'b0000000010})
      $display("FAIL fwd_timing got pr=%h pl=%h done=%h pos=%b exp pr=0006 pl=0018 done=0040 pos=0000000010",
               pr_mask, pl_mask, done_mask, o_pos);
    else passed++;
    total++;
  endtask

  task automatic test_set_reverse();
    int cl_cnt = 0;
    bit left_first = 1'b0;
    set = 1'b1; in_v = 10'b0000000010;
    tick();
    set = 1'b0;
    if (o_pos !== 10'b0000000010) $display("FAIL set_load got=%b exp=0000000010", o_pos);
    else passed++;
    total++;
    req = 1'b1; dir = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      req = 1'b0;
      if (obs !== exp_vec()) $display("FAIL rev_cycle c=%0d got=%h exp=%h", c, obs, exp_vec());
      else passed++;
      total++;
      if (c == 1) left_first = !o_pl_n && o_pr_n;
      cl_cnt += int'(o_cl);
    end
    if ({left_first, o_pos, cl_cnt[3:0]} !== {1'b1, 10'b0000000001, 4'd0})
      $display("FAIL rev_result got left_first=%0b pos=%b carry_low=%0d exp 1 0000000001 0", left_first, o_pos, cl_cnt);
    else passed++;
    total++;
  endtask

  task automatic test_wrap();
    int ch_cnt = 0, cl_cnt = 0;
    set = 1'b1; in_v = 10'b1000000000;
    tick();
    set = 1'b0;
    req = 1'b1; dir = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      req = 1'b0;
      if (obs !== exp_vec()) $display("FAIL wrap_fwd c=%0d got=%h exp=%h", c, obs, exp_vec());
      else passed++;
      total++;
      ch_cnt += int'(o_ch);
    end
    if (ch_cnt != 1 || o_pos !== 10'b0000000001)
      $display("FAIL wrap_fwd_result got carry_high=%0d pos=%b exp 1 0000000001", ch_cnt, o_pos);
    else passed++;
    total++;
    req = 1'b1; dir = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      req = 1'b0;
      if (obs !== exp_vec()) $display("FAIL wrap_rev c=%0d got=%h exp=%h", c, obs, exp_vec());
      else passed++;
      total++;
      cl_cnt += int'(o_cl);
    end
    if (cl_cnt != 1 || o_pos !== 10'b1000000000)
      $display("FAIL wrap_rev_result got carry_low=%0d pos=%b exp 1 1000000000", cl_cnt, o_pos);
    else passed++;
    total++;
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0, ch_cnt = 0, last = 0;
    set = 1'b1; in_v = 10'b0000000001;
    tick();
    set = 1'b0;
    req = 1'b1; dir = 1'b0;
    for (int c = 1; c <= 62; c++) begin
      tick();
      if (c == 55) req = 1'b0;
      if (obs !== exp_vec()) $display("FAIL b2b_cycle c=%0d got=%h exp=%h", c, obs, exp_vec());
      else passed++;
      total++;
      if (o_done) begin
        done_cnt++;
        if (c - last != 6) $display("FAIL b2b_spacing got=%0d exp=6", c - last);
        else passed++;
        total++;
        last = c;
      end
      ch_cnt += int'(o_ch);
    end
    if (done_cnt != 10 || ch_cnt != 1 || o_pos !== 10'b0000000001)
      $display("FAIL b2b_result got done=%0d carry_high=%0d pos=%b exp 10 1 0000000001", done_cnt, ch_cnt, o_pos);
    else passed++;
    total++;
  endtask

  task automatic test_rst_mid_step();
    bit done6 = 1'b0;
    req = 1'b1; dir = 1'b0;
    tick();
    req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (obs !== 16'b0011_0000_0000_0100) $display("FAIL rst_mid got=%h exp=%h", obs, 16'b0011_0000_0000_0100);
    else passed++;
    total++;
    req = 1'b1; dir = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      req = 1'b0; set = 1'b0;
      if (c == 2) begin
        set = 1'b1; in_v = 10'h100; req = 1'b1; dir = 1'b0;
      end
      if (obs !== exp_vec()) $display("FAIL mid_ignore c=%0d got=%h exp=%h", c, obs, exp_vec());
      else passed++;
      total++;
      if (c == 6) done6 = o_done;
    end
    if (!done6 || o_pos !== 10'b1000000000)
      $display("FAIL mid_ignore_result got done6=%0b pos=%b exp 1 1000000000", done6, o_pos);
    else passed++;
    total++;
  endtask

  task automatic test_set_req_priority();
    int activity = 0;
    set = 1'b1; req = 1'b1; dir = 1'b0; in_v = 10'b0000100000;
    tick();
    set = 1'b0; req = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (obs !== exp_vec()) $display("FAIL prio_cycle c=%0d got=%h exp=%h", c, obs, exp_vec());
      else passed++;
      total++;
      if (!o_pr_n || !o_pl_n || o_done || o_busy) activity++;
      tick();
    end
    if (activity != 0 || o_pos !== 10'b0000100000)
      $display("FAIL prio_result got activity=%0d pos=%b exp 0 0000100000", activity, o_pos);
    else passed++;
    total++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 39) == 0);
      set  = ($urandom_range(0, 7) == 0);
      req  = 1'($urandom_range(0, 1));
      dir  = 1'($urandom_range(0, 1));
      in_v = 10'($urandom);
      if ($urandom_range(0, 5) == 0) in_v = 10'd0;
      tick();
      if (obs !== exp_vec()) $display("FAIL random n=%0d got=%h exp=%h", n, obs, exp_vec());
      else passed++;
      total++;
    end
    rst = 1'b0; set = 1'b0; req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward_step();
    test_set_reverse();
    test_wrap();
    test_back_to_back();
    test_rst_mid_step();
    test_set_req_priority();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dekatron_step_sequencer.md
DEKATRON_STEP_SEQUENCER -- requirements
Module: dekatron_step_sequencer

Interface
REQ-001 Parameter PULSE_LEN, default 2: clock cycles each guide pulse is held low; legal range 1-15.
REQ-002 Parameter SETTLE_LEN, default 1: idle cycles after the second guide pulse before the step completes; legal range 0-15.
REQ-003 Clk  in  1  single clock; all state changes on rising edge.
REQ-004 Rst  in  1  synchronous reset, active-high.
REQ-005 Req  in  1  step request, sampled only in IDLE.
REQ-006 Dir  in  1  step direction, sampled with Req: 0 forward (cathode index +1), 1 reverse (index -1).
REQ-007 Set  in  1  load strobe, sampled only in IDLE.
REQ-008 In  in  10  one-hot position to load on Set.
REQ-009 Busy  out  1  high from the cycle after acceptance through the last SETTLE cycle.
REQ-010 Done  out  1  one-cycle pulse on step completion.
REQ-011 PulseRight_n  out  1  guide-1 drive, active-low.
REQ-012 PulseLeft_n  out  1  guide-2 drive, active-low.
REQ-013 Pos  out  10  one-hot shadow of the glowing cathode.
REQ-014 CarryHigh  out  1  one-cycle pulse on forward wrap 9->0.
REQ-015 CarryLow  out  1  one-cycle pulse on reverse wrap 0->9.

Function
REQ-016 FSM states: IDLE, G1, G2, SETTLE; a single cycle counter times G1, G2 and SETTLE.
REQ-017 IDLE: Req=1 and Set=0 -> latch Dir, enter G1 next cycle, clear the counter.
REQ-018 G1: guide pulse A low for exactly PULSE_LEN cycles; A = PulseRight_n when Dir=0, PulseLeft_n when Dir=1.
REQ-019 G2: the other guide pulse low for exactly PULSE_LEN cycles; both guide outputs never low in the same cycle.
REQ-020 Exit from G2: Pos rotates one place (left for forward, i.e. bit k -> bit k+1, bit 9 -> bit 0; right for reverse), registered and visible in the first cycle after G2.
REQ-021 Carry pulses are asserted in the same cycle that the wrapped Pos first becomes visible.
REQ-022 SETTLE: both guides high for SETTLE_LEN cycles; SETTLE_LEN=0 skips the state.
REQ-023 Done asserts for one cycle when returning to IDLE; Busy is low in that cycle.
REQ-024 Step latency Req acceptance -> Done = 2*PULSE_LEN + SETTLE_LEN + 1 cycles; Busy high for 2*PULSE_LEN + SETTLE_LEN cycles.
REQ-025 Req or Set while Busy is ignored; requests are not queued.
REQ-026 Back-to-back: Req held high in the Done cycle is accepted in that cycle; no idle bubble is required beyond it.
REQ-027 Set in IDLE loads Pos from In in the next cycle and produces no guide pulses, no carry, no Done.
REQ-028 Set and Req both high in IDLE: Set wins, Req is dropped.
REQ-029 In not one-hot: Pos loads the lowest set bit of In; In all-zero loads 10'b0000000001.
REQ-030 Dir changes after acceptance have no effect on the step in progress.

Reset
REQ-031 Rst=1 at a rising edge forces IDLE, the counter to 0, Pos=10'b0000000001, PulseRight_n=PulseLeft_n=1, and Busy=Done=CarryHigh=CarryLow=0, overriding all other inputs.
REQ-032 Rst asserted mid-step aborts the step; Pos does not advance and the guide outputs are high in the next cycle.

Verification (PULSE_LEN=2, SETTLE_LEN=1)
REQ-033 Reset, then one Req with Dir=0 -> PulseRight_n low for cycles 1-2, PulseLeft_n low for cycles 3-4, Done in cycle 6, Pos=0000000010.
REQ-034 Set with In=0000000010 -> Pos=0000000010; then Req with Dir=1 -> PulseLeft_n low first, Pos=0000000001, CarryLow stays 0.
REQ-035 Set with In=1000000000, then forward step -> Pos=0000000001 and CarryHigh a one-cycle pulse; from Pos=0000000001 a reverse step -> Pos=1000000000 and CarryLow a one-cycle pulse.
REQ-036 Req held high for 10 steps forward from 0 -> 10 Done pulses spaced 6 cycles apart, exactly one CarryHigh, final Pos=0000000001.
REQ-037 Rst pulsed during G2 -> guides high next cycle, Pos=0000000001, Busy=0; Req or Set pulsed mid-step -> no effect on Pos or timing.
REQ-038 Set and Req in the same IDLE cycle with In=0000100000 -> Pos=0000100000, no guide pulses, no Done.
